fp_mult_pipe: RTL and testbench

FP_MULT_PIPE -- requirements
Module: fp_mult_pipe

---
 rtl/fp_mult_pipe.sv | 237 +++++++++++++++++++++++
 tb/tb_fp_mult_pipe.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mult_pipe.sv
// fp_mult_pipe: 3-stage pipelined floating-point multiplier (IEEE-like format).
// S1 unpack/classify, S2 significand multiply, S3 normalise/round/pack.
// Ports: clk, rst_n (async, active-low), in_valid/in_ready, a, b,
//        out_valid/out_ready, out, flags = {invalid, overflow, underflow, inexact}.
// Optional macro FP_MULT_RNE_EN: round-to-nearest-even (default truncates).
// Subnormal inputs are flushed to signed zero.
module fp_mult_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [EXP_W+MAN_W:0]       a,
  input  logic [EXP_W+MAN_W:0]       b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [EXP_W+MAN_W:0]       out,
  output logic [3:0]                 flags
);

  localparam int SW     = MAN_W + 1;
  localparam int PW     = 2 * SW;
  localparam int XW     = EXP_W + 2;
  localparam int BIAS_I = (1 << (EXP_W - 1)) - 1;
  localparam int EMAX_I = (1 << EXP_W) - 1;

  localparam logic signed [XW-1:0] BIAS   = XW'(BIAS_I);
  localparam logic signed [XW-1:0] EMAX_S = XW'(EMAX_I);
  localparam logic signed [XW-1:0] ONE_S  = XW'(1);
  localparam logic signed [XW-1:0] ZERO_S = '0;
  localparam logic [EXP_W-1:0]     EMAX   = '1;

  typedef enum logic [1:0] {
    K_NUM,
    K_NAN,
    K_INF,
    K_ZERO
  } kind_t;

  logic stall;
  logic adv;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;
  assign adv      = !stall;

  // ---------------- S1: unpack / classify ----------------
  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;

  assign {sa, ea, fa} = a;
  assign {sb, eb, fb} = b;

  logic a_max, b_max, a_zero, b_zero;
  logic a_nan, b_nan, a_inf, b_inf;
  logic is_nan, is_inf, is_zero;

  assign a_max  = &ea;
  assign b_max  = &eb;
  assign a_zero = ~|ea;
  assign b_zero = ~|eb;
  assign a_nan  = a_max && |fa;
  assign b_nan  = b_max && |fb;
  assign a_inf  = a_max && ~|fa;
  assign b_inf  = b_max && ~|fb;

  assign is_nan  = a_nan || b_nan
                || (a_inf && b_zero)
                || (a_zero && b_inf);
  assign is_inf  = !is_nan && (a_inf || b_inf);
  assign is_zero = !is_nan && !is_inf
                && (a_zero || b_zero);

  kind_t kind;

  always_comb begin
    kind = K_NUM;
    unique case (1'b1)
      is_nan:  kind = K_NAN;
      is_inf:  kind = K_INF;
      is_zero: kind = K_ZERO;
      default: kind = K_NUM;
    endcase
  end

  logic signed [XW-1:0] exp_sum;

  assign exp_sum = $signed({2'b00, ea})
                 + $signed({2'b00, eb})
                 - BIAS;

  logic                 s1_valid;
  logic                 s1_sign;
  kind_t                s1_kind;
  logic signed [XW-1:0] s1_exp;
  logic [SW-1:0]        s1_siga;
  logic [SW-1:0]        s1_sigb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_kind  <= K_NUM;
      s1_exp   <= '0;
      s1_siga  <= '0;
      s1_sigb  <= '0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_sign  <= sa ^ sb;
      s1_kind  <= kind;
      s1_exp   <= exp_sum;
      s1_siga  <= {1'b1, fa};
      s1_sigb  <= {1'b1, fb};
    end
  end

  // ---------------- S2: significand multiply ----------------
  logic                 s2_valid;
  logic                 s2_sign;
  kind_t                s2_kind;
  logic signed [XW-1:0] s2_exp;
  logic [PW-1:0]        s2_prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_kind  <= K_NUM;
      s2_exp   <= '0;
      s2_prod  <= '0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      s2_sign  <= s1_sign;
      s2_kind  <= s1_kind;
      s2_exp   <= s1_exp;
      s2_prod  <= s1_siga * s1_sigb;
    end
  end

  // ---------------- S3: normalise / round / pack ----------------
  // Product of two [1,2) significands lies in [1,4); the top bit
  // selects which window holds the kept mantissa.
  logic [MAN_W-1:0]     man_n;
  logic                 guard;
  logic                 sticky;
  logic signed [XW-1:0] exp_n;

  always_comb begin
    man_n  = '0;
    guard  = 1'b0;
    sticky = 1'b0;
    exp_n  = s2_exp;
    if (s2_prod[PW-1]) begin
      man_n  = s2_prod[PW-2 -: MAN_W];
      guard  = s2_prod[MAN_W];
      sticky = |s2_prod[MAN_W-1:0];
      exp_n  = s2_exp + ONE_S;
    end else begin
      man_n  = s2_prod[PW-3 -: MAN_W];
      guard  = s2_prod[MAN_W-1];
      sticky = |s2_prod[MAN_W-2:0];
    end
  end

  logic inexact;
  logic rnd_up;

  assign inexact = guard | sticky;

`ifdef FP_MULT_RNE_EN
  assign rnd_up = guard & (sticky | man_n[0]);
`else
  assign rnd_up = 1'b0;
`endif

  // Carry out of the mantissa leaves it all-zero and bumps the exponent.
  logic [MAN_W:0]       man_r;
  logic signed [XW-1:0] exp_f;
  logic                 ovf;
  logic                 unf;

  assign man_r = {1'b0, man_n}
               + {{MAN_W{1'b0}}, rnd_up};
  assign exp_f = exp_n
               + $signed({{(XW-1){1'b0}}, man_r[MAN_W]});
  assign ovf   = exp_f >= EMAX_S;
  assign unf   = exp_f <= ZERO_S;

  logic [EXP_W+MAN_W:0] res;
  logic [3:0]           flg;

  always_comb begin
    res = '0;
    flg = 4'b0000;
    unique case (s2_kind)
      K_NAN: begin
        res = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};
        flg = 4'b1000;
      end
      K_INF: begin
        res = {s2_sign, EMAX, {MAN_W{1'b0}}};
      end
      K_ZERO: begin
        res = {s2_sign, {(EXP_W+MAN_W){1'b0}}};
      end
      default: begin
        if (ovf) begin
          res = {s2_sign, EMAX, {MAN_W{1'b0}}};
          flg = 4'b0101;
        end else if (unf) begin
          res = {s2_sign, {(EXP_W+MAN_W){1'b0}}};
          flg = 4'b0011;
        end else begin
          res = {s2_sign, exp_f[EXP_W-1:0],
                 man_r[MAN_W-1:0]};
          flg = {3'b000, inexact};
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out       <= '0;
      flags     <= 4'b0000;
    end else if (adv) begin
      out_valid <= s2_valid;
      out       <= res;
      flags     <= flg;
    end
  end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// tb_fp_mult_pipe: self-checking bench for fp_mult_pipe (binary32).
// Directed vectors, stall/back-pressure, reset mid-stream, random traffic.
module tb_fp_mult_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic [3:0]  flags;

  int checks = 0;
  int errors = 0;

  logic [35:0] sb[$];

  always #5 clk = ~clk;

  fp_mult_pipe #(
    .EXP_W(8),
    .MAN_W(23)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (out),
    .flags    (flags)
  );

  // Reference: exact integer product, scaled to a 24-bit significand.
  function automatic logic [35:0] ref_mul(
    input logic [31:0] x,
    input logic [31:0] y
  );
    int     ex, ey, e, sh;
    longint fx, fy, p, keep, rem, half;
    logic   s, inx;
    logic   xnan, ynan, xinf, yinf, xz, yz;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    fx = longint'(x[22:0]);
    fy = longint'(y[22:0]);
    xnan = (ex == 255) && (fx != 0);
    ynan = (ey == 255) && (fy != 0);
    xinf = (ex == 255) && (fx == 0);
    yinf = (ey == 255) && (fy == 0);
    xz   = (ex == 0);
    yz   = (ey == 0);
    if (xnan || ynan || (xinf && yz) || (xz && yinf))
      return {32'h7FC00000, 4'b1000};
    s = x[31] ^ y[31];
    if (xinf || yinf)
      return {s, 8'hFF, 23'd0, 4'b0000};
    if (xz || yz)
      return {s, 31'd0, 4'b0000};
    p = (fx + (longint'(1) << 23)) * (fy + (longint'(1) << 23));
    e = ex + ey - 127;
    sh = 23;
    if (p >= (longint'(1) << 47)) begin
      sh = 24;
      e++;
    end
    keep = p >>> sh;
    rem  = p - (keep << sh);
    half = longint'(1) << (sh - 1);
    inx  = (rem != 0);
`ifdef FP_MULT_RNE_EN
    if (rem > half || (rem == half && (keep % 2) == 1))
      keep++;
    if (keep == (longint'(1) << 24)) begin
      keep = keep >>> 1;
      e++;
    end
`endif
    if (e >= 255)
      return {s, 8'hFF, 23'd0, 4'b0101};
    if (e <= 0)
      return {s, 31'd0, 4'b0011};
    return {s, 8'(e), 23'(keep), 3'b000, inx};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [7:0]  e;
    logic [22:0] m;
    case ($urandom_range(0, 7))
      0:       e = 8'd0;
      1:       e = 8'hFF;
      2, 3:    e = 8'($urandom_range(118, 136));
      4:       e = 8'($urandom_range(1, 70));
      5:       e = 8'($urandom_range(190, 254));
      default: e = 8'($urandom);
    endcase
    if ($urandom_range(0, 3) == 0)
      m = 23'd0;
    else
      m = 23'($urandom);
    return {1'($urandom), e, m};
  endfunction

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got %b want 0", out_valid);
    end
    checks++;
    if (out !== 32'h0) begin
      errors++;
      $display("FAIL reset_out got %h want 0", out);
    end
    checks++;
    if (flags !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 0000", flags);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [31:0] va[6];
    logic [31:0] vb[6];
    logic [31:0] vo[6];
    logic [3:0]  vf[6];
    va[0] = 32'h40780000; vb[0] = 32'h40600000;
    vo[0] = 32'h41590000; vf[0] = 4'b0000;
    va[1] = 32'h7F800000; vb[1] = 32'h00000000;
    vo[1] = 32'h7FC00000; vf[1] = 4'b1000;
    va[2] = 32'hBFC00000; vb[2] = 32'h40000000;
    vo[2] = 32'hC0400000; vf[2] = 4'b0000;
    va[3] = 32'h7F000000; vb[3] = 32'h40000000;
    vo[3] = 32'h7F800000; vf[3] = 4'b0101;
    va[4] = 32'h00800000; vb[4] = 32'h00800000;
    vo[4] = 32'h00000000; vf[4] = 4'b0011;
    va[5] = 32'h3FC00000; vb[5] = 32'h3F800001;
`ifdef FP_MULT_RNE_EN
    vo[5] = 32'h3FC00002;
`else
    vo[5] = 32'h3FC00001;
`endif
    vf[5] = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      a = va[i];
      b = vb[i];
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL dir%0d_early1 valid %b want 0", i, out_valid);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL dir%0d_early2 valid %b want 0", i, out_valid);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out !== vo[i] || flags !== vf[i]) begin
        errors++;
        $display("FAIL dir%0d v=%b out=%h flags=%b want v=1 out=%h flags=%b",
                 i, out_valid, out, flags, vo[i], vf[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] oa[6];
    logic [31:0] ob[6];
    logic [35:0] want;
    logic [31:0] held_o;
    logic [3:0]  held_f;
    logic        held_v;
    int sent, got, stalls;
    for (int i = 0; i < 6; i++) begin
      oa[i] = rand_op();
      ob[i] = rand_op();
    end
    sent = 0;
    got = 0;
    stalls = 0;
    held_v = 1'b0;
    held_o = '0;
    held_f = '0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 8);
      if (sent < 6) begin
        in_valid = 1'b1;
        a = oa[sent];
        b = ob[sent];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (held_v) begin
        checks++;
        if (out_valid !== 1'b1 || out !== held_o || flags !== held_f) begin
          errors++;
          $display("FAIL b2b_hold out=%h flags=%b want %h %b",
                   out, flags, held_o, held_f);
        end
      end
      if (out_valid && !out_ready) begin
        stalls++;
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL b2b_in_ready got %b want 0", in_ready);
        end
      end
      held_v = out_valid && !out_ready;
      held_o = out;
      held_f = flags;
      if (out_valid && out_ready) begin
        want = ref_mul(oa[got], ob[got]);
        checks++;
        if ({out, flags} !== want) begin
          errors++;
          $display("FAIL b2b_res%0d got %h/%b want %h/%b",
                   got, out, flags, want[35:4], want[3:0]);
        end
        got++;
      end
      if (in_valid && in_ready)
        sent++;
      if (got == 6)
        break;
    end
    in_valid = 1'b0;
    checks++;
    if (got != 6) begin
      errors++;
      $display("FAIL b2b_count got %0d want 6", got);
    end
    checks++;
    if (stalls < 5) begin
      errors++;
      $display("FAIL b2b_stall_cycles got %0d want >=5", stalls);
    end
  endtask

  task automatic test_reset_midstream();
    logic [35:0] want;
    int stale;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1;
    a = 32'h40400000;
    b = 32'h40400000;
    @(negedge clk);
    a = 32'h3F800000;
    b = 32'hC0000000;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pre valid %b want 1", out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out !== 32'h0 || flags !== 4'b0) begin
      errors++;
      $display("FAIL rst_mid_clear v=%b out=%h flags=%b want 0",
               out_valid, out, flags);
    end
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0)
        stale++;
    end
    checks++;
    if (stale != 0) begin
      errors++;
      $display("FAIL rst_mid_stale got %0d want 0", stale);
    end
    a = 32'h40A00000;
    b = 32'hC0400000;
    want = ref_mul(a, b);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || {out, flags} !== want) begin
      errors++;
      $display("FAIL rst_mid_next v=%b got %h/%b want %h/%b",
               out_valid, out, flags, want[35:4], want[3:0]);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [35:0] want;
    logic [31:0] held_o;
    logic [3:0]  held_f;
    logic        held_v;
    sb.delete();
    held_v = 1'b0;
    held_o = '0;
    held_f = '0;
    for (int cyc = 0; cyc < 420; cyc++) begin
      @(negedge clk);
      if (cyc < 400) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        a         = rand_op();
        b         = rand_op();
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      #1;
      if (held_v) begin
        checks++;
        if (out_valid !== 1'b1 || out !== held_o || flags !== held_f) begin
          errors++;
          $display("FAIL rnd_hold out=%h flags=%b want %h %b",
                   out, flags, held_o, held_f);
        end
      end
      checks++;
      if (in_ready !== !(out_valid && !out_ready)) begin
        errors++;
        $display("FAIL rnd_in_ready got %b v=%b r=%b",
                 in_ready, out_valid, out_ready);
      end
      held_v = out_valid && !out_ready;
      held_o = out;
      held_f = flags;
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL rnd_extra got %h want no result", out);
        end else begin
          want = sb.pop_front();
          if ({out, flags} !== want) begin
            errors++;
            $display("FAIL rnd_res got %h/%b want %h/%b",
                     out, flags, want[35:4], want[3:0]);
          end
        end
      end
      if (in_valid && in_ready)
        sb.push_back(ref_mul(a, b));
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL rnd_drain left %0d want 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
